// File: rtl/count_ctrl_pkg.sv
// Shared types and default sizes for the triangle-sweep sequencer.
package count_ctrl_pkg;

    localparam int BW_DEF       = 10;
    localparam int PAUSE_BW_DEF = 4;
    localparam int SWP_BW_DEF   = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_UP       = 3'd2,
        ST_PAUSE_HI = 3'd3,
        ST_DOWN     = 3'd4,
        ST_PAUSE_LO = 3'd5,
        ST_DONE     = 3'd6
    } sweep_state_t;

endpackage

// File: rtl/count_sweep_ctrl_if.sv
// Bundle of sequencer control, status and counter-facing signals.
interface count_sweep_ctrl_if
    import count_ctrl_pkg::*;
#(
    parameter int BW       = BW_DEF,
    parameter int PAUSE_BW = PAUSE_BW_DEF,
    parameter int SWP_BW   = SWP_BW_DEF
);
    logic                start;
    logic                stop;
    logic [BW-1:0]       lo_val;
    logic [BW-1:0]       hi_val;
    logic [PAUSE_BW-1:0] pause_len;
    logic [SWP_BW-1:0]   n_sweeps;
    logic [BW-1:0]       cnt;
    logic [BW-1:0]       data_in;
    logic                load;
    logic                en;
    logic                updn;
    logic                busy;
    logic                done;
    logic                err;
    logic [SWP_BW-1:0]   sweep_cnt;

    // Sequencer side: consumes requests and counter value, drives counter and status.
    modport master (
        input  start, stop, lo_val, hi_val, pause_len, n_sweeps, cnt,
        output data_in, load, en, updn, busy, done, err, sweep_cnt
    );

    // System/counter side: the mirror view.
    modport slave (
        output start, stop, lo_val, hi_val, pause_len, n_sweeps, cnt,
        input  data_in, load, en, updn, busy, done, err, sweep_cnt
    );
endinterface

// File: rtl/count_1596.sv
// BW-bit up/down counter with synchronous load (priority) and enable.
module count_1596 #(
    parameter int BW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic          updn,
    input  logic [BW-1:0] data_in,
    output logic [BW-1:0] cnt
);
    logic [BW-1:0] cnt_q;
    logic [BW-1:0] cnt_d;

    // Load wins over counting; updn=1 counts down.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = data_in;
        end else if (en) begin
            if (updn) begin
                cnt_d = cnt_q - BW'(1);
            end else begin
                cnt_d = cnt_q + BW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {BW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
endmodule

// File: rtl/count_sweep_ctrl_dwell_timer.sv
// Dwell timer: loaded on entry to a pause state, expires on its last cycle.
module dwell_timer #(
    parameter int PAUSE_BW = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [PAUSE_BW-1:0] len,
    output logic                expire
);
    logic [PAUSE_BW-1:0] timer_q;
    logic [PAUSE_BW-1:0] timer_d;

    // Reload on pause entry, otherwise count down and park at zero.
    always_comb begin
        timer_d = timer_q;
        if (load) begin
            timer_d = len;
        end else if (timer_q != {PAUSE_BW{1'b0}}) begin
            timer_d = timer_q - PAUSE_BW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= {PAUSE_BW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expire = (timer_q == PAUSE_BW'(1));
endmodule

// File: rtl/count_sweep_ctrl.sv
// Triangle-sweep sequencer driving count_1596: lo -> hi, dwell, hi -> lo, dwell, repeat.
module count_sweep_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int BW       = BW_DEF,
    parameter int PAUSE_BW = PAUSE_BW_DEF,
    parameter int SWP_BW   = SWP_BW_DEF
) (
    input  logic                 clk5m,
    input  logic                 rst_n,
    count_sweep_ctrl_if.master   bus
);
    sweep_state_t        state_q, state_d;
    logic [BW-1:0]       lo_q, lo_d;
    logic [BW-1:0]       hi_q, hi_d;
    logic [PAUSE_BW-1:0] pause_q, pause_d;
    logic [SWP_BW-1:0]   n_q, n_d;
    logic [SWP_BW-1:0]   sweep_cnt_q, sweep_cnt_d;
    logic                err_q, err_d;
    logic                timer_load;
    logic                timer_expire;

    dwell_timer #(.PAUSE_BW(PAUSE_BW)) u_dwell (
        .clk    (clk5m),
        .rst_n  (rst_n),
        .load   (timer_load),
        .len    (pause_q),
        .expire (timer_expire)
    );

    // Next-state, configuration capture, sweep counting and start rejection.
    always_comb begin
        state_d     = state_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        pause_d     = pause_q;
        n_d         = n_q;
        sweep_cnt_d = sweep_cnt_q;
        err_d       = 1'b0;
        if ((state_q != ST_IDLE) && bus.stop) begin
            // Abort: counter freezes because en drops; sweep count is kept.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.stop) begin
                        if (bus.lo_val >= bus.hi_val) begin
                            err_d = 1'b1;
                        end else begin
                            lo_d        = bus.lo_val;
                            hi_d        = bus.hi_val;
                            pause_d     = bus.pause_len;
                            n_d         = bus.n_sweeps;
                            sweep_cnt_d = {SWP_BW{1'b0}};
                            state_d     = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: state_d = ST_UP;
                ST_UP: begin
                    // Counter reaches hi_q on the same edge we leave UP.
                    if (bus.cnt == (hi_q - BW'(1))) begin
                        state_d = (pause_q == {PAUSE_BW{1'b0}}) ? ST_DOWN : ST_PAUSE_HI;
                    end else begin
                        state_d = ST_UP;
                    end
                end
                ST_PAUSE_HI: state_d = timer_expire ? ST_DOWN : ST_PAUSE_HI;
                ST_DOWN: begin
                    if (bus.cnt == (lo_q + BW'(1))) begin
                        sweep_cnt_d = sweep_cnt_q + SWP_BW'(1);
                        if ((n_q != {SWP_BW{1'b0}}) && (sweep_cnt_d == n_q)) begin
                            state_d = ST_DONE;
                        end else if (pause_q == {PAUSE_BW{1'b0}}) begin
                            state_d = ST_UP;
                        end else begin
                            state_d = ST_PAUSE_LO;
                        end
                    end else begin
                        state_d = ST_DOWN;
                    end
                end
                ST_PAUSE_LO: state_d = timer_expire ? ST_UP : ST_PAUSE_LO;
                ST_DONE:     state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Pause entry strobes the dwell timer so a pause lasts exactly pause_q cycles.
    always_comb begin
        timer_load = 1'b0;
        if (((state_d == ST_PAUSE_HI) && (state_q != ST_PAUSE_HI)) ||
            ((state_d == ST_PAUSE_LO) && (state_q != ST_PAUSE_LO))) begin
            timer_load = 1'b1;
        end else begin
            timer_load = 1'b0;
        end
    end

    // State, configuration and status registers.
    always_ff @(posedge clk5m or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lo_q        <= {BW{1'b0}};
            hi_q        <= {BW{1'b0}};
            pause_q     <= {PAUSE_BW{1'b0}};
            n_q         <= {SWP_BW{1'b0}};
            sweep_cnt_q <= {SWP_BW{1'b0}};
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            pause_q     <= pause_d;
            n_q         <= n_d;
            sweep_cnt_q <= sweep_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.load      = (state_q == ST_LOAD);
    assign bus.en        = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign bus.updn      = (state_q == ST_DOWN);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.err       = err_q;
    assign bus.data_in   = lo_q;
    assign bus.sweep_cnt = sweep_cnt_q;
endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Directed self-checking bench for count_sweep_ctrl driving a real count_1596.
module tb_count_sweep_ctrl;
    import count_ctrl_pkg::*;

    logic clk5m;
    logic rst_n;
    logic cnt_rst_n;
    int   n_checks;
    int   n_fail;

    count_sweep_ctrl_if #(.BW(10), .PAUSE_BW(4), .SWP_BW(8)) bus ();

    count_sweep_ctrl #(.BW(10), .PAUSE_BW(4), .SWP_BW(8)) dut (
        .clk5m (clk5m),
        .rst_n (rst_n),
        .bus   (bus)
    );

    count_1596 #(.BW(10)) u_cnt (
        .clk     (clk5m),
        .rst_n   (cnt_rst_n),
        .load    (bus.load),
        .en      (bus.en),
        .updn    (bus.updn),
        .data_in (bus.data_in),
        .cnt     (bus.cnt)
    );

    initial clk5m = 1'b0;
    always #5 clk5m = ~clk5m;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk5m);
        #1;
    endtask

    // lo=2 hi=5 pause=2 n=1; optional start pulse and hi_val change mid-run.
    task automatic run_sweep1(input bit disturb);
        int exp_cnt [9] = '{2, 3, 4, 5, 5, 5, 4, 3, 2};
        bit exp_en;
        bus.lo_val = 10'd2; bus.hi_val = 10'd5; bus.pause_len = 4'd2; bus.n_sweeps = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("s1_load_c1", bus.load, 1);
        check_eq("s1_busy_c1", bus.busy, 1);
        for (int c = 2; c <= 10; c++) begin
            tick();
            exp_en = ((c >= 2) && (c <= 4)) || ((c >= 7) && (c <= 9));
            check_eq($sformatf("s1_cnt_c%0d", c), bus.cnt, exp_cnt[c-2]);
            check_eq($sformatf("s1_en_c%0d", c), bus.en, exp_en);
            check_eq($sformatf("s1_done_c%0d", c), bus.done, (c == 10));
            check_eq($sformatf("s1_load_c%0d", c), bus.load, 0);
            if (disturb && (c == 3)) begin
                bus.start = 1'b1;
                bus.hi_val = 10'd9;
            end else if (disturb && (c == 5)) begin
                bus.start = 1'b0;
            end else begin
                bus.start = bus.start;
            end
        end
        tick();
        check_eq("s1_busy_c11", bus.busy, 0);
        check_eq("s1_done_c11", bus.done, 0);
        check_eq("s1_swcnt_c11", bus.sweep_cnt, 1);
        check_eq("s1_cnt_c11", bus.cnt, 2);
        bus.hi_val = 10'd5;
    endtask

    initial begin
        int exp2 [13] = '{10, 11, 12, 11, 10, 11, 12, 11, 10, 11, 12, 11, 10};
        int done_seen;
        int load_seen;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; cnt_rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;
        bus.lo_val = '0; bus.hi_val = '0; bus.pause_len = '0; bus.n_sweeps = '0;
        tick(); tick();
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_load", bus.load, 0);
        check_eq("rst_en", bus.en, 0);
        check_eq("rst_data_in", bus.data_in, 0);
        check_eq("rst_sweep_cnt", bus.sweep_cnt, 0);
        check_eq("rst_err", bus.err, 0);
        rst_n = 1'b1; cnt_rst_n = 1'b1;
        tick();

        // Single sweep with dwell
        run_sweep1(1'b0);

        // Three sweeps, no dwell
        bus.lo_val = 10'd10; bus.hi_val = 10'd12; bus.pause_len = 4'd0; bus.n_sweeps = 8'd3;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_seen = 0;
        for (int c = 2; c <= 14; c++) begin
            tick();
            check_eq($sformatf("s2_cnt_c%0d", c), bus.cnt, exp2[c-2]);
            check_eq($sformatf("s2_en_c%0d", c), bus.en, (c <= 13));
            if (bus.done) done_seen++;
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_eq("s2_done_count", done_seen, 1);
        check_eq("s2_sweep_cnt", bus.sweep_cnt, 3);
        check_eq("s2_busy_end", bus.busy, 0);

        // Rejected start
        bus.lo_val = 10'd7; bus.hi_val = 10'd7; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check_eq("s3_err_c1", bus.err, 1);
        check_eq("s3_busy_c1", bus.busy, 0);
        load_seen = 0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_eq($sformatf("s3_err_c%0d", c), bus.err, 0);
            check_eq($sformatf("s3_busy_c%0d", c), bus.busy, 0);
            if (bus.load) load_seen++;
        end
        check_eq("s3_load_seen", load_seen, 0);

        // Abort in endless mode
        bus.lo_val = 10'd0; bus.hi_val = 10'd1023; bus.pause_len = 4'd0; bus.n_sweeps = 8'd0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        done_seen = 0;
        for (int i = 0; (i < 400) && (bus.cnt != 10'd300); i++) begin
            tick();
            if (bus.done) done_seen++;
        end
        check_eq("s4_reach300", bus.cnt, 300);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_eq("s4_en_after", bus.en, 0);
        check_eq("s4_busy_after", bus.busy, 0);
        check_eq("s4_cnt_after", bus.cnt, 301);
        tick(); tick();
        check_eq("s4_cnt_hold", bus.cnt, 301);
        check_eq("s4_swcnt", bus.sweep_cnt, 0);
        if (bus.done) done_seen++;
        check_eq("s4_no_done", done_seen, 0);

        // Ignored start/hi_val change while busy
        run_sweep1(1'b1);

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check_eq("s5_ss_busy", bus.busy, 0);
        check_eq("s5_ss_load", bus.load, 0);
        check_eq("s5_ss_err", bus.err, 0);
        tick();
        check_eq("s5_ss_busy2", bus.busy, 0);

        // Asynchronous reset mid-DOWN, then fresh run
        bus.lo_val = 10'd2; bus.hi_val = 10'd5; bus.pause_len = 4'd2; bus.n_sweeps = 8'd1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        check_eq("s6_updn_pre", bus.updn, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s6_busy_rst", bus.busy, 0);
        check_eq("s6_en_rst", bus.en, 0);
        check_eq("s6_updn_rst", bus.updn, 0);
        check_eq("s6_data_in_rst", bus.data_in, 0);
        check_eq("s6_swcnt_rst", bus.sweep_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_sweep1(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
